// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and sizing helpers for the PLL reset sequencer
// Purpose: sequencer state encoding, loss counter width and timer width helper.
// Ports: none (package).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  // The timer only has to hold values up to (longest interval - 1).
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the PLL locked status
// Purpose: brings the asynchronous PLL lock indication into the clk domain.
// Ports:
//   clk       destination clock
//   rst_n     asynchronous active-low reset, clears both flops to 0
//   async_in  asynchronous input
//   sync_out  synchronized output, two clk cycles of latency
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and staggered domain reset release
// Build option: define PLL_SEQ_LOSS_CNT_EN to implement lock_loss_cnt; otherwise it is tied to 0.
// Ports:
//   clk            free-running reference clock
//   reset_n        asynchronous active-low reset
//   pll_locked     raw PLL lock status (asynchronous, synchronized inside)
//   restart_req    one-cycle request to restart the whole sequence
//   pll_rst        active-high PLL reset
//   domain_rst_n   active-low domain resets, bit 0 released first
//   ready          sequence complete, domains running
//   fault          lock retries exhausted
//   retry_cnt      lock timeouts in the current sequence
//   lock_loss_cnt  saturating count of lock losses seen while running
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  input  logic                               restart_req,
  output logic                               pll_rst,
  output logic [NUM_DOMAINS-1:0]             domain_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [LOSS_CNT_W-1:0]              lock_loss_cnt
);

  localparam int TW = timer_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(RELEASE_GAP_CYCLES - 1);

  seq_state_e             state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [RW-1:0]          retry_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   lock_s;
  logic                   loss_inc;

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .rst_n    (reset_n),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  // Outputs are registered from the next state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ASSERT_RST;
      timer        <= '0;
      retry_cnt    <= '0;
      domain_rst_n <= '0;
      pll_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      retry_cnt    <= retry_d;
      domain_rst_n <= dom_d;
      pll_rst      <= (state_d == ASSERT_RST) || (state_d == FAULT);
      ready        <= (state_d == RUN);
      fault        <= (state_d == FAULT);
    end
  end

  always_comb begin
    state_d  = state;
    timer_d  = timer + TW'(1);
    retry_d  = retry_cnt;
    dom_d    = domain_rst_n;
    loss_inc = 1'b0;

    if (restart_req) begin
      // Restart wins over everything, including a coincident lock loss in RUN.
      state_d = ASSERT_RST;
      timer_d = '0;
      retry_d = '0;
      dom_d   = '0;
    end else begin
      case (state)
        ASSERT_RST: begin
          if (timer == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer == TIMEOUT_LAST) begin
            retry_d = retry_cnt + RW'(1);
            state_d = (retry_d == RW'(MAX_RETRIES)) ? FAULT : ASSERT_RST;
            timer_d = '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer == STABLE_LAST) begin
            state_d = RELEASE;
            timer_d = '0;
            dom_d   = NUM_DOMAINS'(1);
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = ASSERT_RST;
            timer_d = '0;
            dom_d   = '0;
          end else if (&domain_rst_n) begin
            state_d = RUN;
            timer_d = '0;
            retry_d = '0;
          end else if (timer == GAP_LAST) begin
            // Thermometer shift: the next higher domain comes out of reset.
            dom_d   = (domain_rst_n << 1) | NUM_DOMAINS'(1);
            timer_d = '0;
          end
        end
        RUN: begin
          timer_d = '0;
          if (!lock_s) begin
            state_d  = ASSERT_RST;
            dom_d    = '0;
            loss_inc = 1'b1;
          end
        end
        FAULT: begin
          timer_d = '0;
        end
        default: begin
          state_d = ASSERT_RST;
          timer_d = '0;
          dom_d   = '0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else if (loss_inc && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  logic unused_loss_inc;
  assign unused_loss_inc = loss_inc;
  assign lock_loss_cnt   = '0;
`endif

endmodule
